shift_add_multiplier: RTL and testbench

Sequential unsigned WIDTH×WIDTH multiplier using the radix-2 shift-and-add algorithm, one partial product per clock. It is the arithmetic inverse of the team's restoring divider and sits beside it in the datapath. It uses the same `start`/`busy`/`ready`/`counter` handshake, so one controller can drive either unit.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/mult_adder.sv | 21 ++
 rtl/shift_add_multiplier.sv | 81 ++++++++
 tb/tb_shift_add_multiplier.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions for the multiplier and divider datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arith_pkg;

  // Default operand width for the sequential arithmetic units.
  localparam int ARITH_WIDTH = 16;

  // Iteration counter width: it must be able to represent the value WIDTH itself.
  function automatic int arith_cw(input int width);
    return $clog2(width) + 1;
  endfunction

  // Controller state, common to the multiplier and the divider.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arith_state_e;

endpackage

// File: rtl/mult_adder.sv
// Gated WIDTH+1-bit adder for one shift-and-add partial-product step.
// Latency: combinational.
// Backpressure: none.
// Ports: acc (WIDTH+1) running accumulator, addend (WIDTH) multiplicand,
//        sel adds the multiplicand when set, sum (WIDTH+1) result.
module mult_adder #(
  parameter int WIDTH = arith_pkg::ARITH_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] addend,
  input  logic             sel,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] gated;

  // Addend is zero-extended so the carry lands in sum[WIDTH] and is never lost.
  assign gated = sel ? {1'b0, addend} : '0;
  assign sum   = acc + gated;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH radix-2 shift-and-add multiplier.
// Latency: WIDTH+1 edges from the start edge to ready; start always accepted (aborts any run).
// Backpressure: none; ready holds the result until the next start or clear.
// Ports: clk, clear (async active-low), start, a, b in; product, busy, ready, counter out.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH,
  parameter int CW    = arith_cw(WIDTH)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 ready,
  output logic [CW-1:0]        counter
);

  arith_state_e     state_q;
  arith_state_e     state_d;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] reg_q;
  logic [WIDTH:0]   sum;
  logic             last_step;

  mult_adder #(.WIDTH(WIDTH)) u_adder (
    .acc    (acc),
    .addend (reg_a),
    .sel    (reg_q[0]),
    .sum    (sum)
  );

  // The step that takes counter from WIDTH-1 to WIDTH finishes the product.
  assign last_step = (counter == CW'(WIDTH - 1));
  assign busy      = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = BUSY;
    end else if (state_q == BUSY && last_step) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      reg_a   <= '0;
      acc     <= '0;
      reg_q   <= '0;
      counter <= '0;
      product <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        // Restart from any state; the previous product stays visible.
        reg_a   <= a;
        reg_q   <= b;
        acc     <= '0;
        counter <= '0;
        ready   <= 1'b0;
      end else if (state_q == BUSY) begin
        // {sum, reg_q} shifted right by one as a single 2*WIDTH+1-bit value.
        acc     <= {1'b0, sum[WIDTH:1]};
        reg_q   <= {sum[0], reg_q[WIDTH-1:1]};
        counter <= counter + CW'(1);
        if (last_step) begin
          product <= {sum, reg_q[WIDTH-1:1]};
          ready   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_add_multiplier;

  localparam int W  = 16;
  localparam int CW = 5;

  logic              clk;
  logic              clear;
  logic              start;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic [2*W-1:0]    product;
  logic              busy;
  logic              ready;
  logic [CW-1:0]     counter;

  int checks   = 0;
  int failures = 0;

  shift_add_multiplier #(.WIDTH(W), .CW(CW)) dut (
    .clk     (clk),
    .clear   (clear),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .ready   (ready),
    .counter (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // busy and ready must never be high together while out of reset.
  always @(negedge clk) begin
    if (clear === 1'b1) begin
      checks++;
      if (busy === 1'b1 && ready === 1'b1) begin
        failures++;
        $display("FAIL busy_ready_overlap: got busy=1 ready=1 expected not both");
      end
    end
  end

  // Drive start for exactly one edge; returns at the following negedge.
  task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts edges after the start edge until ready is seen; also flags any early ready.
  task automatic wait_ready(output int edges);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) break;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready_timeout: got ready=0 expected 1 within 40 edges");
    end
  endtask

  // Waits at negedges until counter reaches n, noting whether ready ever rose.
  task automatic wait_counter(input int n, output bit saw_ready);
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready) saw_ready = 1'b1;
      if (counter == CW'(n)) break;
      @(posedge clk);
      @(negedge clk);
    end
    if (counter != CW'(n)) begin
      checks++;
      failures++;
      $display("FAIL wait_counter_timeout: got counter=%0d expected %0d", counter, n);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int  edges;
    bit  saw;
    logic [2*W-1:0] held;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[3] = '{16'h1234, 16'h0001, 32'h0000_1234};
    vecs[4] = '{16'hABCD, 16'h1234, 32'h0C37_4FA4};
    vecs[5] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[7] = '{16'h00FF, 16'h0100, 32'h0000_FF00};

    clear = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state.
    #12;
    chk("rst_product", 64'(product), 64'h0);
    chk("rst_busy",    64'(busy),    64'h0);
    chk("rst_ready",   64'(ready),   64'h0);
    chk("rst_counter", 64'(counter), 64'h0);
    @(negedge clk);
    clear = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      pulse_start(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_after_start", i), 64'(busy),    64'h1);
      chk($sformatf("v%0d_cnt_after_start", i),  64'(counter), 64'h0);
      wait_ready(edges);
      chk($sformatf("v%0d_latency", i), 64'(edges + 1), 64'd17);
      chk($sformatf("v%0d_product", i), 64'(product),   64'(vecs[i].exp));
      chk($sformatf("v%0d_counter", i), 64'(counter),   64'd16);
      chk($sformatf("v%0d_busy", i),    64'(busy),      64'h0);
    end

    // ready and product hold while idle.
    held = product;
    repeat (5) @(negedge clk);
    chk("hold_ready",   64'(ready),   64'h1);
    chk("hold_product", 64'(product), 64'(held));
    chk("hold_counter", 64'(counter), 64'd16);

    // Abort mid-run and restart with new operands.
    pulse_start(16'h00FF, 16'h0100);
    chk("abort_ready_cleared", 64'(ready), 64'h0);
    chk("abort_product_kept",  64'(product), 64'(held));
    wait_counter(7, saw);
    pulse_start(16'h0002, 16'h0003);
    chk("abort_counter_reset", 64'(counter), 64'h0);
    wait_ready(edges);
    chk("abort_no_early_ready", 64'(saw),       64'h0);
    chk("abort_latency",        64'(edges + 1), 64'd17);
    chk("abort_product",        64'(product),   64'h6);

    // Asynchronous clear between edges.
    pulse_start(16'h0003, 16'h0005);
    wait_counter(9, saw);
    #2 clear = 1'b0;
    #1;
    chk("clr_product", 64'(product), 64'h0);
    chk("clr_busy",    64'(busy),    64'h0);
    chk("clr_ready",   64'(ready),   64'h0);
    chk("clr_counter", 64'(counter), 64'h0);
    @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_clr_product", 64'(product), 64'h0);
    chk("post_clr_busy",    64'(busy),    64'h0);
    chk("post_clr_ready",   64'(ready),   64'h0);
    chk("post_clr_counter", 64'(counter), 64'h0);

    // start on the edge where ready would rise.
    pulse_start(16'h0003, 16'h0005);
    wait_counter(15, saw);
    a     = 16'h8000;
    b     = 16'h0002;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_ready",   64'(ready),   64'h0);
    chk("b2b_busy",    64'(busy),    64'h1);
    chk("b2b_counter", 64'(counter), 64'h0);
    wait_ready(edges);
    chk("b2b_latency", 64'(edges + 1), 64'd17);
    chk("b2b_product", 64'(product),   64'h0001_0000);

    // start held for several edges reloads each time; iteration starts after release.
    @(negedge clk);
    a     = 16'h0007;
    b     = 16'h0009;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_start_counter", 64'(counter), 64'h0);
    chk("hold_start_busy",    64'(busy),    64'h1);
    start = 1'b0;
    wait_ready(edges);
    chk("hold_start_iter_edges", 64'(edges),   64'd16);
    chk("hold_start_product",    64'(product), 64'd63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
